// File: rtl/id_ex_control_pipe.sv
// id_ex_control_pipe: decodes the ID opcode into the registered ID/EX control bundle and sequences multi-cycle MUL
module id_ex_control_pipe #(
  parameter int OP_W       = 6,
  parameter int CMD_W      = 4,
  parameter int MC_LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  op_code,
  input  logic             in_valid,
  input  logic             hazard_detected,
  input  logic             flush,
  output logic             ex_valid,
  output logic [CMD_W-1:0] ex_exe_cmd,
  output logic [1:0]       ex_br_cmd,
  output logic             ex_branch_en,
  output logic             ex_is_imm,
  output logic             ex_st_or_bne,
  output logic             ex_wb_en,
  output logic             ex_mem_r_en,
  output logic             ex_mem_w_en,
  output logic             stall_out,
  output logic             illegal_op
);
  localparam int CW = $clog2(MC_LATENCY) + 1;
  typedef enum logic {IDLE, MULTI} state_t;
  typedef struct packed {
    logic             valid;
    logic [CMD_W-1:0] cmd;
    logic [1:0]       br;
    logic             ben;
    logic             imm;
    logic             sob;
    logic             wb;
    logic             mr;
    logic             mw;
  } ctrl_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  ctrl_t q, q_n, dec;
  logic illegal_n, legal, is_mul;
  always_comb begin
    dec = '0;
    legal = 1'b1;
    is_mul = 1'b0;
    case (int'(op_code))
      1:  begin dec.cmd = CMD_W'(0);  dec.wb = 1'b1; end
      3:  begin dec.cmd = CMD_W'(2);  dec.wb = 1'b1; end
      5:  begin dec.cmd = CMD_W'(4);  dec.wb = 1'b1; end
      6:  begin dec.cmd = CMD_W'(5);  dec.wb = 1'b1; end
      7:  begin dec.cmd = CMD_W'(6);  dec.wb = 1'b1; end
      8:  begin dec.cmd = CMD_W'(7);  dec.wb = 1'b1; end
      9:  begin dec.cmd = CMD_W'(8);  dec.wb = 1'b1; end
      10: begin dec.cmd = CMD_W'(8);  dec.wb = 1'b1; end
      11: begin dec.cmd = CMD_W'(9);  dec.wb = 1'b1; end
      12: begin dec.cmd = CMD_W'(10); dec.wb = 1'b1; end
      13: begin dec.cmd = CMD_W'(11); dec.wb = 1'b1; is_mul = 1'b1; end
      32: begin dec.cmd = CMD_W'(0);  dec.wb = 1'b1; dec.imm = 1'b1; end
      33: begin dec.cmd = CMD_W'(2);  dec.wb = 1'b1; dec.imm = 1'b1; end
      36: begin dec.wb = 1'b1; dec.imm = 1'b1; dec.sob = 1'b1; dec.mr = 1'b1; end
      37: begin dec.imm = 1'b1; dec.sob = 1'b1; dec.mw = 1'b1; end
      40: begin dec.cmd = CMD_W'(15); dec.imm = 1'b1; dec.br = 2'd3; dec.ben = 1'b1; end
      41: begin dec.cmd = CMD_W'(15); dec.imm = 1'b1; dec.br = 2'd1; dec.ben = 1'b1; dec.sob = 1'b1; end
      42: begin dec.cmd = CMD_W'(15); dec.imm = 1'b1; dec.br = 2'd2; dec.ben = 1'b1; end
      default: legal = 1'b0;
    endcase
    dec.valid = legal;
  end
  always_comb begin
    q_n = '0;
    state_n = IDLE;
    cnt_n = '0;
    illegal_n = 1'b0;
    if (!flush && state == MULTI) begin
      q_n = q;
      cnt_n = cnt - CW'(1);
      state_n = cnt == CW'(1) ? IDLE : MULTI;
    end else if (!flush && !hazard_detected && in_valid) begin
      q_n = dec;
      illegal_n = !legal;
      if (is_mul && MC_LATENCY > 1) begin
        state_n = MULTI;
        cnt_n = CW'(MC_LATENCY - 1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      q <= '0;
      illegal_op <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      q <= q_n;
      illegal_op <= illegal_n;
    end
  end
  assign stall_out = state == MULTI;
  assign ex_valid = q.valid;
  assign ex_exe_cmd = q.cmd;
  assign ex_br_cmd = q.br;
  assign ex_branch_en = q.ben;
  assign ex_is_imm = q.imm;
  assign ex_st_or_bne = q.sob;
  assign ex_wb_en = q.wb;
  assign ex_mem_r_en = q.mr;
  assign ex_mem_w_en = q.mw;
endmodule

// File: tb/tb_id_ex_control_pipe.sv
// tb_id_ex_control_pipe: directed checks of decode, bubbles, flush, MUL sequencing and illegal-op pulse
module tb_id_ex_control_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, hazard_detected, flush;
  logic [5:0] op_code;
  logic ex_valid, ex_branch_en, ex_is_imm, ex_st_or_bne, ex_wb_en, ex_mem_r_en, ex_mem_w_en;
  logic stall_out, illegal_op;
  logic [3:0] ex_exe_cmd;
  logic [1:0] ex_br_cmd;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  id_ex_control_pipe #(.OP_W(6), .CMD_W(4), .MC_LATENCY(4)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .in_valid(in_valid),
    .hazard_detected(hazard_detected), .flush(flush), .ex_valid(ex_valid),
    .ex_exe_cmd(ex_exe_cmd), .ex_br_cmd(ex_br_cmd), .ex_branch_en(ex_branch_en),
    .ex_is_imm(ex_is_imm), .ex_st_or_bne(ex_st_or_bne), .ex_wb_en(ex_wb_en),
    .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en), .stall_out(stall_out),
    .illegal_op(illegal_op)
  );
  function automatic logic [14:0] mk(input logic v, input logic [3:0] cmd, input logic [1:0] br,
      input logic ben, imm, sob, wb, mr, mw, st, il);
    return {v, cmd, br, ben, imm, sob, wb, mr, mw, st, il};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [14:0] exp);
    logic [14:0] obs;
    obs = {ex_valid, ex_exe_cmd, ex_br_cmd, ex_branch_en, ex_is_imm, ex_st_or_bne,
           ex_wb_en, ex_mem_r_en, ex_mem_w_en, stall_out, illegal_op};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [5:0] op, input logic iv, hz, fl);
    op_code = op;
    in_valid = iv;
    hazard_detected = hz;
    flush = fl;
  endtask
  initial begin
    rst = 1'b1;
    drive(6'd13, 1, 0, 0);
    tick();
    check("rst1", '0);
    tick();
    check("rst2", '0);
    rst = 1'b0;
    drive(6'd36, 1, 0, 0); tick(); check("ld", mk(1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0));
    drive(6'd41, 1, 1, 0); tick(); check("bne_hazard", '0);
    drive(6'd41, 1, 0, 0); tick(); check("bne", mk(1, 15, 1, 1, 1, 1, 0, 0, 0, 0, 0));
    drive(6'd40, 1, 0, 0); tick(); check("bez", mk(1, 15, 3, 1, 1, 0, 0, 0, 0, 0, 0));
    drive(6'd37, 1, 0, 0); tick(); check("st", mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
    drive(6'd32, 1, 0, 0); tick(); check("addi", mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    drive(6'd10, 1, 0, 0); tick(); check("op10", mk(1, 8, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    drive(6'd10, 0, 0, 0); tick(); check("not_valid", '0);
    drive(6'd13, 1, 0, 0); tick(); check("mul_c1", mk(1, 11, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    drive(6'd3, 0, 1, 0);  tick(); check("mul_c2", mk(1, 11, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    tick(); check("mul_c3", mk(1, 11, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    drive(6'd3, 1, 0, 0);  tick(); check("mul_c4", mk(1, 11, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tick(); check("after_mul", mk(1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    drive(6'd13, 1, 0, 0); tick(); check("fmul_c1", mk(1, 11, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    tick(); check("fmul_c2", mk(1, 11, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    drive(6'd13, 1, 0, 1); tick(); check("flush_mid_mul", '0);
    drive(6'd13, 0, 0, 0); tick(); check("idle_after_flush", '0);
    drive(6'd1, 1, 0, 0);  tick(); check("op1", mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    drive(6'd63, 1, 0, 0); tick(); check("illegal", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    drive(6'd1, 1, 0, 0);  tick(); check("illegal_pulse_end", mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    drive(6'd63, 0, 0, 0); tick(); check("illegal_no_valid", '0);
    drive(6'd63, 1, 0, 1); tick(); check("illegal_flushed", '0);
    drive(6'd13, 1, 0, 0); tick(); check("b2b_mul1", mk(1, 11, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    tick(); tick(); tick(); check("b2b_mul1_end", mk(1, 11, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tick(); check("b2b_mul2", mk(1, 11, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    drive(6'd0, 0, 0, 0);
    tick(); tick(); tick(); check("b2b_mul2_end", mk(1, 11, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tick(); check("final_bubble", '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
